dmac_wr_engine: RTL and testbench

DMAC_WR_ENGINE -- requirements
Module: dmac_wr_engine

---
 rtl/dmac_pkg.sv | 31 +++
 rtl/dmac_wr_engine.sv | 186 ++++++++++++++++++
 tb/tb_dmac_wr_engine.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmac_pkg
// Description : Shared types and constants for the DMA write engine: FSM
//               state encoding, AXI size/burst/response encodings, beat size.
// Revision    : 1.0 - initial release
// ============================================================================
package dmac_pkg;

  // Write engine FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_t;

  // AXI encodings used by the engine
  localparam logic [2:0] C_AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] C_AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] C_AXI_RESP_OKAY  = 2'b00;

  // Every beat moves one 32-bit word
  localparam int C_BEAT_BYTES = 4;
  localparam int C_BEAT_SHIFT = 2;

  // Word counter width: a 16-bit byte length holds at most 2^14 words
  localparam int C_WORDS_W = 14;

endpackage : dmac_pkg
`default_nettype wire

// File: rtl/dmac_wr_engine.sv
`default_nettype none
// ============================================================================
// Module      : dmac_wr_engine
// Description : Drains an upstream FIFO into AXI INCR write bursts of up to
//               MAX_BURST 4-byte beats, one AW/W/B round per burst.
//               Optional macro DMAC_WR_BRESP_CHECK_EN: a non-OKAY write
//               response sets the sticky err_o and abandons the transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module dmac_wr_engine
  import dmac_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // transfer command
  input  logic                      start_i,
  input  logic [ADDR_WIDTH-1:0]     dst_addr_i,
  input  logic [15:0]               byte_len_i,
  output logic                      done_o,
  output logic                      err_o,
  // upstream FIFO read side
  input  logic                      fifo_empty_i,
  output logic                      fifo_rden_o,
  input  logic [DATA_WIDTH-1:0]     fifo_rdata_i,
  // AXI AW
  output logic                      awvalid_o,
  input  logic                      awready_i,
  output logic [ADDR_WIDTH-1:0]     awaddr_o,
  output logic [3:0]                awlen_o,
  output logic [2:0]                awsize_o,
  output logic [1:0]                awburst_o,
  // AXI W
  output logic                      wvalid_o,
  input  logic                      wready_i,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic [DATA_WIDTH/8-1:0]   wstrb_o,
  output logic                      wlast_o,
  // AXI B
  input  logic                      bvalid_i,
  output logic                      bready_o,
  input  logic [1:0]                bresp_i
);

  localparam logic [C_WORDS_W-1:0] c_max_words = C_WORDS_W'(MAX_BURST);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [C_WORDS_W-1:0]    r_remain;
  logic [4:0]              r_beat;

  logic [4:0]              w_beats;
  logic [4:0]              w_last_idx;
  logic                    w_final;
  logic                    w_start;
  logic                    w_bresp_err;
  logic [C_WORDS_W-1:0]    w_remain_after;

  // Burst sizing: remaining words capped at MAX_BURST. r_remain only changes
  // in B, so the AW fields stay stable while awvalid_o waits for awready_i.
  assign w_beats        = (r_remain < c_max_words) ? r_remain[4:0] : 5'(MAX_BURST);
  assign w_last_idx     = w_beats - 5'd1;
  assign w_final        = (r_beat == w_last_idx);
  assign w_start        = start_i && (byte_len_i != 16'd0);
  assign w_remain_after = r_remain - C_WORDS_W'(w_beats);

  assign done_o    = (r_state == ST_IDLE);
  assign awaddr_o  = r_addr;
  assign awlen_o   = w_last_idx[3:0];
  assign awsize_o  = C_AXI_SIZE_4B;
  assign awburst_o = C_AXI_BURST_INCR;
  assign wdata_o   = fifo_rdata_i;
  assign wstrb_o   = '1;

`ifdef DMAC_WR_BRESP_CHECK_EN
  logic r_err;

  assign w_bresp_err = (bresp_i != C_AXI_RESP_OKAY);
  assign err_o       = r_err;

  // Sticky error flag: cleared by an accepted command, set by a bad response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_start) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_B) && bvalid_i && w_bresp_err) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused_bresp;

  assign w_unused_bresp = ^bresp_i;
  assign w_bresp_err    = 1'b0;
  assign err_o          = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and handshake outputs; every valid is low outside its state
  always_comb begin
    w_state_nxt = r_state;
    awvalid_o   = 1'b0;
    wvalid_o    = 1'b0;
    wlast_o     = 1'b0;
    bready_o    = 1'b0;
    fifo_rden_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_AW;
        end
      end
      ST_AW: begin
        awvalid_o = 1'b1;
        if (awready_i) begin
          w_state_nxt = ST_W;
        end
      end
      ST_W: begin
        wvalid_o    = ~fifo_empty_i;
        wlast_o     = wvalid_o & w_final;
        fifo_rden_o = wvalid_o & wready_i;
        if (fifo_rden_o && w_final) begin
          w_state_nxt = ST_B;
        end
      end
      ST_B: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          if (w_bresp_err || (w_remain_after == '0)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_AW;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address, remaining-word and beat counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_remain <= '0;
      r_beat   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_addr   <= dst_addr_i;
            r_remain <= byte_len_i[15:C_BEAT_SHIFT];
            r_beat   <= '0;
          end
        end
        ST_W: begin
          if (fifo_rden_o) begin
            r_beat <= w_final ? 5'd0 : r_beat + 5'd1;
          end
        end
        ST_B: begin
          if (bvalid_i) begin
            r_addr   <= r_addr + (ADDR_WIDTH'(w_beats) << C_BEAT_SHIFT);
            r_remain <= w_bresp_err ? '0 : w_remain_after;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : dmac_wr_engine
`default_nettype wire

// File: tb/tb_dmac_wr_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmac_wr_engine
// Description : Directed self-checking bench for dmac_wr_engine.
//               Expectations follow DMAC_WR_BRESP_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmac_wr_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] dst_addr_i;
  logic [15:0] byte_len_i;
  logic        done_o, err_o;
  logic        fifo_empty_i, fifo_rden_o;
  logic [31:0] fifo_rdata_i;
  logic        awvalid_o, awready_i;
  logic [31:0] awaddr_o;
  logic [3:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic        wvalid_o, wready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o;
  logic        bvalid_i, bready_o;
  logic [1:0]  bresp_i;

  dmac_wr_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .dst_addr_i   (dst_addr_i),
    .byte_len_i   (byte_len_i),
    .done_o       (done_o),
    .err_o        (err_o),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rden_o  (fifo_rden_o),
    .fifo_rdata_i (fifo_rdata_i),
    .awvalid_o    (awvalid_o),
    .awready_i    (awready_i),
    .awaddr_o     (awaddr_o),
    .awlen_o      (awlen_o),
    .awsize_o     (awsize_o),
    .awburst_o    (awburst_o),
    .wvalid_o     (wvalid_o),
    .wready_i     (wready_i),
    .wdata_o      (wdata_o),
    .wstrb_o      (wstrb_o),
    .wlast_o      (wlast_o),
    .bvalid_i     (bvalid_i),
    .bready_o     (bready_o),
    .bresp_i      (bresp_i)
  );

  always #5 clk = ~clk;

  // FIFO model
  logic [31:0] fifo_mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic        hold_empty = 1'b0;
  logic        flush = 1'b0;
  assign fifo_empty_i = hold_empty || (rd_ptr == wr_ptr);
  assign fifo_rdata_i = fifo_mem[rd_ptr];

  // expected data in push order
  logic [31:0] exp_d [64];
  int          n_push;

  // monitor state
  logic        clr = 1'b0;
  int          aw_n, w_n, wl_n, wl_idx, b_n, pop_n, aw_unstable, w_early, strb_bad;
  logic [31:0] aw_addr [8];
  logic [3:0]  aw_len  [8];
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [31:0] w_data  [64];
  logic        aw_pend;
  logic [31:0] pa;
  logic [3:0]  pl;

  // wready driver: fixed level or toggling every cycle
  logic        tog_en = 1'b0;
  logic        wr_level = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture AXI handshakes and protocol violations at the active edge
  always @(posedge clk) begin
    if (clr) begin
      aw_n <= 0; w_n <= 0; wl_n <= 0; wl_idx <= -1; b_n <= 0; pop_n <= 0;
      aw_unstable <= 0; w_early <= 0; strb_bad <= 0; aw_pend <= 1'b0;
    end else begin
      if (awvalid_o) begin
        if (aw_pend && (awaddr_o != pa || awlen_o != pl)) aw_unstable <= aw_unstable + 1;
        aw_pend <= !awready_i;
        pa <= awaddr_o;
        pl <= awlen_o;
      end else begin
        aw_pend <= 1'b0;
      end
      if (awvalid_o && awready_i) begin
        if (aw_n < 8) begin
          aw_addr[aw_n] <= awaddr_o;
          aw_len[aw_n]  <= awlen_o;
        end
        aw_size  <= awsize_o;
        aw_burst <= awburst_o;
        aw_n     <= aw_n + 1;
      end
      if (wvalid_o && aw_n == 0) w_early <= w_early + 1;
      if (wvalid_o && wready_i) begin
        if (w_n < 64) w_data[w_n] <= wdata_o;
        if (wstrb_o != 4'hF) strb_bad <= strb_bad + 1;
        if (wlast_o) begin
          wl_n   <= wl_n + 1;
          wl_idx <= w_n;
        end
        w_n <= w_n + 1;
      end
      if (bvalid_i && bready_o) b_n <= b_n + 1;
      if (fifo_rden_o) pop_n <= pop_n + 1;
    end
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rden_o) rd_ptr <= rd_ptr + 8'd1;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tog_en) wready_i = ~wready_i;
      else        wready_i = wr_level;
    end
  end

  task automatic prep();
    clr = 1'b1; flush = 1'b1; n_push = 0;
    @(negedge clk);
    clr = 1'b0; flush = 1'b0;
  endtask

  task automatic push(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr] = base + 32'(i);
      exp_d[n_push]    = base + 32'(i);
      wr_ptr           = wr_ptr + 8'd1;
      n_push++;
    end
  endtask

  task automatic go(input logic [31:0] addr, input logic [15:0] len);
    dst_addr_i = addr; byte_len_i = len; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while (!done_o && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk(tag, done_o, 1);
  endtask

  task automatic wait_beats(input string tag, input int k);
    int i = 0;
    while (w_n < k && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk(tag, w_n, k);
  endtask

  function automatic int data_bad();
    int bad = 0;
    for (int i = 0; i < w_n && i < 64; i++)
      if (w_data[i] !== exp_d[i]) bad++;
    return bad;
  endfunction

  initial begin
    rst_n = 1'b0; start_i = 1'b0; dst_addr_i = '0; byte_len_i = '0;
    awready_i = 1'b1; bvalid_i = 1'b1; bresp_i = 2'b00;
    prep();
    repeat (3) @(negedge clk);
    chk("rst_done", done_o, 1);
    chk("rst_err", err_o, 0);
    chk("rst_valids", {awvalid_o, wvalid_o, wlast_o, bready_o, fifo_rden_o}, 5'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // zero length command is ignored
    go(32'h0000_1000, 16'd0);
    chk("zero_len_done", done_o, 1);
    chk("zero_len_aw", awvalid_o, 0);

    // single 16-beat burst
    prep();
    push(16, 32'hA000_0000);
    go(32'h0000_1000, 16'd64);
    chk("t1_busy", done_o, 0);
    wait_done("t1_done");
    chk("t1_aw_n", aw_n, 1);
    chk("t1_awaddr", aw_addr[0], 32'h0000_1000);
    chk("t1_awlen", aw_len[0], 15);
    chk("t1_awsize", aw_size, 3'b010);
    chk("t1_awburst", aw_burst, 2'b01);
    chk("t1_beats", w_n, 16);
    chk("t1_wlast_n", wl_n, 1);
    chk("t1_wlast_idx", wl_idx, 15);
    chk("t1_data", data_bad(), 0);
    chk("t1_strb", strb_bad, 0);
    chk("t1_b_n", b_n, 1);
    chk("t1_err", err_o, 0);

    // 72 bytes: 16-beat burst then 2-beat burst
    prep();
    push(18, 32'hB000_0000);
    go(32'h0000_1000, 16'd72);
    wait_done("t2_done");
    chk("t2_aw_n", aw_n, 2);
    chk("t2_awaddr0", aw_addr[0], 32'h0000_1000);
    chk("t2_awlen0", aw_len[0], 15);
    chk("t2_awaddr1", aw_addr[1], 32'h0000_1040);
    chk("t2_awlen1", aw_len[1], 1);
    chk("t2_pops", pop_n, 18);
    chk("t2_beats", w_n, 18);
    chk("t2_wlast_n", wl_n, 2);
    chk("t2_data", data_bad(), 0);

    // FIFO runs dry for 5 cycles after beat 3
    prep();
    push(16, 32'hC000_0000);
    go(32'h0000_3000, 16'd64);
    wait_beats("t3_reach3", 3);
    hold_empty = 1'b1;
    begin
      int viol = 0;
      for (int i = 0; i < 5; i++) begin
        #1;
        if (wvalid_o || fifo_rden_o || wlast_o) viol++;
        @(negedge clk);
      end
      chk("t3_stall_viol", viol, 0);
    end
    chk("t3_frozen", w_n, 3);
    hold_empty = 1'b0;
    wait_done("t3_done");
    chk("t3_beats", w_n, 16);
    chk("t3_wlast_idx", wl_idx, 15);
    chk("t3_data", data_bad(), 0);

    // awready held off 4 cycles, wready toggling
    prep();
    push(16, 32'hD000_0000);
    awready_i = 1'b0;
    tog_en = 1'b1;
    go(32'h0000_2000, 16'd64);
    repeat (4) @(negedge clk);
    chk("t4_aw_wait", awvalid_o, 1);
    chk("t4_aw_addr", awaddr_o, 32'h0000_2000);
    awready_i = 1'b1;
    wait_done("t4_done");
    tog_en = 1'b0;
    chk("t4_aw_stable", aw_unstable, 0);
    chk("t4_w_early", w_early, 0);
    chk("t4_beats", w_n, 16);
    chk("t4_pops", pop_n, 16);
    chk("t4_wlast_n", wl_n, 1);
    chk("t4_data", data_bad(), 0);

    // error response on the first of two bursts
    prep();
    push(32, 32'hE000_0000);
    bresp_i = 2'b10;
    go(32'h0000_4000, 16'd128);
    wait_done("t5_done");
    bresp_i = 2'b00;
`ifdef DMAC_WR_BRESP_CHECK_EN
    chk("t5_aw_n", aw_n, 1);
    chk("t5_beats", w_n, 16);
    chk("t5_err", err_o, 1);
`else
    chk("t5_aw_n", aw_n, 2);
    chk("t5_beats", w_n, 32);
    chk("t5_err", err_o, 0);
`endif

    // reset in the middle of the W phase
    prep();
    push(16, 32'hF000_0000);
    go(32'h0000_5000, 16'd64);
    wait_beats("t6_reach6", 6);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_valids", {awvalid_o, wvalid_o, wlast_o, bready_o, fifo_rden_o}, 5'b0);
    chk("t6_done", done_o, 1);
    chk("t6_err", err_o, 0);
    rst_n = 1'b1;
    prep();
    push(1, 32'h1234_5678);
    go(32'h0000_6000, 16'd4);
    wait_done("t6b_done");
    chk("t6b_aw_n", aw_n, 1);
    chk("t6b_awaddr", aw_addr[0], 32'h0000_6000);
    chk("t6b_awlen", aw_len[0], 0);
    chk("t6b_beats", w_n, 1);
    chk("t6b_wlast_idx", wl_idx, 0);
    chk("t6b_data", w_data[0], 32'h1234_5678);
    chk("t6b_err", err_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_dmac_wr_engine
`default_nettype wire
